// File: rtl/hasti_arbiter.sv
// hasti_arbiter -- two-master to one-port HASTI (AHB-Lite) arbiter.
//
// Lets two bus masters (vscale core and a DMA/debug master) share the single
// master port of hasti_bus. The address phase is muxed from the granted
// master. The data-phase owner is tracked so write data and responses are
// routed to the correct master. A master that loses arbitration is stalled
// through its own hready. If a master's data phase completes while that master
// is still stalled on its next address, the response is buffered in a
// per-master hold register and presented once the master is released.
//
// Configuration macro: HASTI_ARB_FIXED_PRIO_EN
//   undefined : round-robin between the two masters when both request
//   defined   : master 0 always wins when both request (lock still honoured)
//
// Ports
//   hclk, hreset           clock; synchronous active-high reset
//   m0_* / m1_*            master request inputs (haddr, hwrite, hsize,
//                          hburst, hprot, htrans, hmastlock, hwdata) and
//                          response outputs (hrdata, hready, hresp)
//   b_*                    request outputs towards hasti_bus and its
//                          response inputs (hrdata, hready, hresp)
//   hmaster                current address-phase grant (0 = M0, 1 = M1)
module hasti_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  // master 0
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic              m0_hwrite,
  input  logic [2:0]        m0_hsize,
  input  logic [2:0]        m0_hburst,
  input  logic [3:0]        m0_hprot,
  input  logic [1:0]        m0_htrans,
  input  logic              m0_hmastlock,
  input  logic [DATA_W-1:0] m0_hwdata,
  output logic [DATA_W-1:0] m0_hrdata,
  output logic              m0_hready,
  output logic              m0_hresp,
  // master 1
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic              m1_hwrite,
  input  logic [2:0]        m1_hsize,
  input  logic [2:0]        m1_hburst,
  input  logic [3:0]        m1_hprot,
  input  logic [1:0]        m1_htrans,
  input  logic              m1_hmastlock,
  input  logic [DATA_W-1:0] m1_hwdata,
  output logic [DATA_W-1:0] m1_hrdata,
  output logic              m1_hready,
  output logic              m1_hresp,
  // shared bus side
  output logic [ADDR_W-1:0] b_haddr,
  output logic              b_hwrite,
  output logic [2:0]        b_hsize,
  output logic [2:0]        b_hburst,
  output logic [3:0]        b_hprot,
  output logic [1:0]        b_htrans,
  output logic              b_hmastlock,
  output logic [DATA_W-1:0] b_hwdata,
  input  logic [DATA_W-1:0] b_hrdata,
  input  logic              b_hready,
  input  logic              b_hresp,
  output logic              hmaster
);

  typedef enum logic [1:0] {
    DOWN_NONE = 2'b00,
    DOWN_M0   = 2'b01,
    DOWN_M1   = 2'b10
  } downer_t;

  // Registered state and its next-state values
  logic              last_g,   last_g_nxt;
  logic              aowner,   aowner_nxt;
  logic              lock_r,   lock_nxt;
  downer_t           downer,   downer_nxt;
  logic [1:0]        hold_v,   hold_v_nxt;
  logic [1:0]        hold_resp, hold_resp_nxt;
  logic [DATA_W-1:0] hold_data     [2];
  logic [DATA_W-1:0] hold_data_nxt [2];

  // Per-master handshake terms (bit i belongs to master i)
  logic [1:0] req;
  logic [1:0] acc;
  logic [1:0] own;
  logic [1:0] dph_done;
  logic [1:0] rdy;
  logic       grant;
  logic       req_g;
  logic       lock_g;

  assign req = {m1_htrans[1], m0_htrans[1]};
  assign own = {downer == DOWN_M1, downer == DOWN_M0};

  // Address-phase grant: lock override, then arbitration, else park on owner
  always_comb begin
    grant = aowner;
    if (lock_r && req[aowner]) begin
      grant = aowner;
    end else if (req == 2'b11) begin
`ifdef HASTI_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_g;
`endif
    end else if (req[0]) begin
      grant = 1'b0;
    end else if (req[1]) begin
      grant = 1'b1;
    end else begin
      grant = aowner;
    end
  end

  assign req_g   = req[grant];
  assign lock_g  = grant ? m1_hmastlock : m0_hmastlock;
  assign hmaster = grant;

  // Address/control mux; a parked or reset grant shows IDLE to the bus
  always_comb begin
    if (grant) begin
      b_haddr     = m1_haddr;
      b_hwrite    = m1_hwrite;
      b_hsize     = m1_hsize;
      b_hburst    = m1_hburst;
      b_hprot     = m1_hprot;
      b_hmastlock = m1_hmastlock;
    end else begin
      b_haddr     = m0_haddr;
      b_hwrite    = m0_hwrite;
      b_hsize     = m0_hsize;
      b_hburst    = m0_hburst;
      b_hprot     = m0_hprot;
      b_hmastlock = m0_hmastlock;
    end
    if (hreset || !req_g) begin
      b_htrans = 2'b00;
    end else begin
      b_htrans = grant ? m1_htrans : m0_htrans;
    end
  end

  // Write data follows the data-phase owner (M0 when nobody owns it)
  assign b_hwdata = (downer == DOWN_M1) ? m1_hwdata : m0_hwdata;

  // Handshake: a master is released once its address is accepted and its
  // previous data phase has finished (either on the bus or into the hold)
  always_comb begin
    acc[0]      = !req[0] || (!grant && b_hready);
    acc[1]      = !req[1] || (grant && b_hready);
    dph_done[0] = !own[0] || b_hready || hold_v[0];
    dph_done[1] = !own[1] || b_hready || hold_v[1];
    rdy         = acc & dph_done;
  end

  // Response routing: held response first, then live bus response for the owner
  always_comb begin
    m0_hready = hreset | rdy[0];
    m1_hready = hreset | rdy[1];
    m0_hrdata = hold_v[0] ? hold_data[0] : (own[0] ? b_hrdata : {DATA_W{1'b0}});
    m1_hrdata = hold_v[1] ? hold_data[1] : (own[1] ? b_hrdata : {DATA_W{1'b0}});
    if (hreset) begin
      m0_hresp = 1'b0;
      m1_hresp = 1'b0;
    end else begin
      m0_hresp = hold_v[0] ? hold_resp[0] : (own[0] & b_hresp);
      m1_hresp = hold_v[1] ? hold_resp[1] : (own[1] & b_hresp);
    end
  end

  // Next-state: arbitration state advances only on bus-ready cycles
  always_comb begin
    last_g_nxt = last_g;
    aowner_nxt = aowner;
    lock_nxt   = lock_r;
    downer_nxt = downer;
    if (b_hready) begin
      aowner_nxt = grant;
      lock_nxt   = lock_g && req_g;
      if (req_g) begin
        last_g_nxt = grant;
        downer_nxt = grant ? DOWN_M1 : DOWN_M0;
      end else begin
        last_g_nxt = last_g;
        downer_nxt = DOWN_NONE;
      end
    end else begin
      last_g_nxt = last_g;
      aowner_nxt = aowner;
      lock_nxt   = lock_r;
      downer_nxt = downer;
    end
    // Capture a finished data phase whose master is still stalled on its
    // next address; capture and release cannot coincide since acc is low.
    for (int i = 0; i < 2; i++) begin
      hold_v_nxt[i]    = hold_v[i];
      hold_resp_nxt[i] = hold_resp[i];
      hold_data_nxt[i] = hold_data[i];
      if (rdy[i]) begin
        hold_v_nxt[i] = 1'b0;
      end else if (own[i] && b_hready && !acc[i]) begin
        hold_v_nxt[i]    = 1'b1;
        hold_resp_nxt[i] = b_hresp;
        hold_data_nxt[i] = b_hrdata;
      end else begin
        hold_v_nxt[i] = hold_v[i];
      end
    end
  end

  // State register with synchronous active-high reset
  always_ff @(posedge hclk) begin
    if (hreset) begin
      last_g       <= 1'b1;
      aowner       <= 1'b0;
      lock_r       <= 1'b0;
      downer       <= DOWN_NONE;
      hold_v       <= 2'b00;
      hold_resp    <= 2'b00;
      hold_data[0] <= {DATA_W{1'b0}};
      hold_data[1] <= {DATA_W{1'b0}};
    end else begin
      last_g       <= last_g_nxt;
      aowner       <= aowner_nxt;
      lock_r       <= lock_nxt;
      downer       <= downer_nxt;
      hold_v       <= hold_v_nxt;
      hold_resp    <= hold_resp_nxt;
      hold_data[0] <= hold_data_nxt[0];
      hold_data[1] <= hold_data_nxt[1];
    end
  end

endmodule

// File: tb/tb_hasti_arbiter.sv
// Testbench for hasti_arbiter: directed scenarios followed by a randomized
// run with two AHB-Lite master agents, a wait-state/ERROR-inserting slave and
// a per-master reference memory (disjoint address regions per master).
module tb_hasti_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
`ifdef HASTI_ARB_FIXED_PRIO_EN
  localparam int WAIT_LIMIT = 400;
`else
  localparam int WAIT_LIMIT = 30;
`endif

  logic hclk = 1'b0;
  logic hreset;
  logic [1:0][31:0] m_haddr, m_hwdata, m_hrdata;
  logic [1:0]       m_hwrite, m_hmastlock, m_hready, m_hresp;
  logic [1:0][2:0]  m_hsize, m_hburst;
  logic [1:0][3:0]  m_hprot;
  logic [1:0][1:0]  m_htrans;
  logic [31:0] b_haddr, b_hwdata, b_hrdata;
  logic        b_hwrite, b_hmastlock, b_hready, b_hresp, hmaster;
  logic [2:0]  b_hsize, b_hburst;
  logic [3:0]  b_hprot;
  logic [1:0]  b_htrans;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 hclk = ~hclk;

  hasti_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .hclk(hclk), .hreset(hreset),
    .m0_haddr(m_haddr[0]), .m0_hwrite(m_hwrite[0]), .m0_hsize(m_hsize[0]),
    .m0_hburst(m_hburst[0]), .m0_hprot(m_hprot[0]), .m0_htrans(m_htrans[0]),
    .m0_hmastlock(m_hmastlock[0]), .m0_hwdata(m_hwdata[0]),
    .m0_hrdata(m_hrdata[0]), .m0_hready(m_hready[0]), .m0_hresp(m_hresp[0]),
    .m1_haddr(m_haddr[1]), .m1_hwrite(m_hwrite[1]), .m1_hsize(m_hsize[1]),
    .m1_hburst(m_hburst[1]), .m1_hprot(m_hprot[1]), .m1_htrans(m_htrans[1]),
    .m1_hmastlock(m_hmastlock[1]), .m1_hwdata(m_hwdata[1]),
    .m1_hrdata(m_hrdata[1]), .m1_hready(m_hready[1]), .m1_hresp(m_hresp[1]),
    .b_haddr(b_haddr), .b_hwrite(b_hwrite), .b_hsize(b_hsize), .b_hburst(b_hburst),
    .b_hprot(b_hprot), .b_htrans(b_htrans), .b_hmastlock(b_hmastlock),
    .b_hwdata(b_hwdata), .b_hrdata(b_hrdata), .b_hready(b_hready), .b_hresp(b_hresp),
    .hmaster(hmaster)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_m(input int i, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic lk);
    m_htrans[i]    = tr;
    m_haddr[i]     = a;
    m_hwrite[i]    = wr;
    m_hmastlock[i] = lk;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      set_m(i, IDLE, 32'h0, 1'b0, 1'b0);
      m_hsize[i]  = 3'b010;
      m_hburst[i] = 3'b000;
      m_hprot[i]  = 4'b0011;
      m_hwdata[i] = 32'h0;
    end
    b_hready = 1'b1;
    b_hresp  = 1'b0;
    b_hrdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_all();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
  endtask

  function automatic logic is_err(input logic [31:0] a);
    return a[5:2] == 4'd13;
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 1) ? 32'h0000_0400 : 32'h0000_0000;
  endfunction

  // Random-phase agent, slave and reference state
  logic [31:0] ref_mem [512];
  logic [31:0] slv_mem [512];
  logic [1:0]  ap_v, ap_wr, dp_v, dp_wr;
  logic [1:0][31:0] ap_addr, ap_wdata, dp_addr, dp_wdata;
  int          wait_cnt [2];
  int          done_cnt [2];
  logic        s_v, s_wr, s_errph;
  logic [31:0] s_addr;
  int          s_wait;

  initial begin
    int h, w, g;
    int c [2];
    logic [7:0] exp_order;
    logic [4:0] hr_seq, rsp_seq;

`ifdef HASTI_ARB_FIXED_PRIO_EN
    h = 1; w = 0; exp_order = 8'b1111_0000;
`else
    h = 0; w = 1; exp_order = 8'b1010_1010;
`endif

    // Reset state
    do_reset();
    b_hrdata = 32'h1111_1111;
    settle();
    chk("rst_hmaster", 32'(hmaster), 32'h0);
    chk("rst_b_htrans", 32'(b_htrans), 32'h0);
    chk("rst_m0_hready", 32'(m_hready[0]), 32'h1);
    chk("rst_m1_hready", 32'(m_hready[1]), 32'h1);
    chk("rst_m0_hrdata", m_hrdata[0], 32'h0);
    chk("rst_m1_hrdata", m_hrdata[1], 32'h0);
    tick();

    // 1: single M0 read
    b_hrdata = 32'h0;
    set_m(0, NONSEQ, 32'h0000_0100, 1'b0, 1'b0);
    settle();
    chk("t1_hmaster_a", 32'(hmaster), 32'h0);
    chk("t1_m0_hready_a", 32'(m_hready[0]), 32'h1);
    chk("t1_m1_hready_a", 32'(m_hready[1]), 32'h1);
    chk("t1_b_haddr", b_haddr, 32'h0000_0100);
    chk("t1_b_htrans", 32'(b_htrans), 32'(NONSEQ));
    chk("t1_b_hsize", 32'(b_hsize), 32'h2);
    chk("t1_b_hprot", 32'(b_hprot), 32'h3);
    tick();
    set_m(0, IDLE, 32'h0, 1'b0, 1'b0);
    b_hrdata = 32'hDEAD_BEEF;
    settle();
    chk("t1_m0_hrdata", m_hrdata[0], 32'hDEAD_BEEF);
    chk("t1_m0_hready_b", 32'(m_hready[0]), 32'h1);
    chk("t1_m1_hready_b", 32'(m_hready[1]), 32'h1);
    chk("t1_m1_hrdata", m_hrdata[1], 32'h0);
    chk("t1_hmaster_b", 32'(hmaster), 32'h0);
    tick();

    // 2: both masters stream 4 transfers each
    do_reset();
    c[0] = 0; c[1] = 0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (c[i] < 4) set_m(i, NONSEQ, base_of(i) + 32'(4 * c[i]), 1'b0, 1'b0);
        else          set_m(i, IDLE, 32'h0, 1'b0, 1'b0);
      end
      settle();
      g = int'(exp_order[k]);
      chk("t2_hmaster", 32'(hmaster), 32'(g));
      chk("t2_b_haddr", b_haddr, base_of(g) + 32'(4 * c[g]));
      chk("t2_win_hready", 32'(m_hready[g]), 32'h1);
      chk("t2_lose_hready", 32'(m_hready[1-g]), (c[1-g] < 4) ? 32'h0 : 32'h1);
      c[g]++;
      tick();
    end

    // 3: locked M0 INCR burst blocks M1 for three beats
    do_reset();
    m_hburst[0] = 3'b001;
    set_m(1, NONSEQ, 32'h0000_0400, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      set_m(0, (k == 0) ? NONSEQ : SEQ, 32'h0000_0200 + 32'(4 * k), 1'b0, 1'b1);
      settle();
      chk("t3_hmaster_lock", 32'(hmaster), 32'h0);
      chk("t3_m1_hready_lock", 32'(m_hready[1]), 32'h0);
      chk("t3_m0_hready_lock", 32'(m_hready[0]), 32'h1);
      chk("t3_b_hmastlock", 32'(b_hmastlock), 32'h1);
      chk("t3_b_hburst", 32'(b_hburst), 32'h1);
      tick();
    end
    set_m(0, IDLE, 32'h0, 1'b0, 1'b0);
    settle();
    chk("t3_hmaster_m1", 32'(hmaster), 32'h1);
    chk("t3_b_haddr_m1", b_haddr, 32'h0000_0400);
    chk("t3_m1_hready_m1", 32'(m_hready[1]), 32'h1);
    chk("t3_m0_hready_m1", 32'(m_hready[0]), 32'h1);
    tick();

    // 4: response held for a master that loses the next grant
    do_reset();
    set_m(h, NONSEQ, 32'h0000_0300, 1'b0, 1'b0);
    settle();
    chk("t4_hmaster_a", 32'(hmaster), 32'(h));
    chk("t4_h_hready_a", 32'(m_hready[h]), 32'h1);
    tick();
    set_m(h, NONSEQ, 32'h0000_0304, 1'b0, 1'b0);
    set_m(w, NONSEQ, 32'h0000_0500, 1'b0, 1'b0);
    b_hrdata = 32'h1234_5678;
    settle();
    chk("t4_hmaster_b", 32'(hmaster), 32'(w));
    chk("t4_h_hready_b", 32'(m_hready[h]), 32'h0);
    chk("t4_w_hready_b", 32'(m_hready[w]), 32'h1);
    tick();
    set_m(w, IDLE, 32'h0, 1'b0, 1'b0);
    b_hrdata = 32'hCAFE_F00D;
    settle();
    chk("t4_hmaster_c", 32'(hmaster), 32'(h));
    chk("t4_h_hready_c", 32'(m_hready[h]), 32'h1);
    chk("t4_h_hrdata_held", m_hrdata[h], 32'h1234_5678);
    chk("t4_w_hrdata_c", m_hrdata[w], 32'hCAFE_F00D);
    chk("t4_w_hready_c", 32'(m_hready[w]), 32'h1);
    tick();
    set_m(h, IDLE, 32'h0, 1'b0, 1'b0);
    b_hrdata = 32'h55AA_55AA;
    settle();
    chk("t4_h_hrdata_live", m_hrdata[h], 32'h55AA_55AA);
    chk("t4_h_hready_d", 32'(m_hready[h]), 32'h1);
    chk("t4_w_hrdata_d", m_hrdata[w], 32'h0);
    tick();

    // 5: three wait states then two-cycle ERROR on an M1 write
    do_reset();
    set_m(1, NONSEQ, 32'h0000_0600, 1'b1, 1'b0);
    settle();
    chk("t5_hmaster_a", 32'(hmaster), 32'h1);
    chk("t5_m1_hready_a", 32'(m_hready[1]), 32'h1);
    chk("t5_b_hwrite", 32'(b_hwrite), 32'h1);
    tick();
    set_m(1, IDLE, 32'h0, 1'b0, 1'b0);
    set_m(0, NONSEQ, 32'h0000_0104, 1'b0, 1'b0);
    m_hwdata[1] = 32'hA1A1_A1A1;
    m_hwdata[0] = 32'h0BAD_0BAD;
    hr_seq  = 5'b10000;
    rsp_seq = 5'b11000;
    for (int j = 0; j < 5; j++) begin
      b_hready = hr_seq[j];
      b_hresp  = rsp_seq[j];
      settle();
      chk("t5_m1_hready", 32'(m_hready[1]), 32'(hr_seq[j]));
      chk("t5_m1_hresp", 32'(m_hresp[1]), 32'(rsp_seq[j]));
      chk("t5_m0_hready", 32'(m_hready[0]), 32'(hr_seq[j]));
      chk("t5_m0_hresp", 32'(m_hresp[0]), 32'h0);
      chk("t5_b_hwdata", b_hwdata, 32'hA1A1_A1A1);
      chk("t5_b_haddr", b_haddr, 32'h0000_0104);
      tick();
    end
    set_m(0, IDLE, 32'h0, 1'b0, 1'b0);
    b_hready = 1'b1;
    b_hresp  = 1'b0;
    settle();
    chk("t5_m0_hready_end", 32'(m_hready[0]), 32'h1);
    chk("t5_m1_hresp_end", 32'(m_hresp[1]), 32'h0);
    chk("t5_b_hwdata_m0", b_hwdata, 32'h0BAD_0BAD);
    tick();

    // 6: reset in the middle of a data phase with a held response pending
    do_reset();
    set_m(h, NONSEQ, 32'h0000_0300, 1'b0, 1'b0);
    tick();
    set_m(h, NONSEQ, 32'h0000_0304, 1'b0, 1'b0);
    set_m(w, NONSEQ, 32'h0000_0500, 1'b0, 1'b0);
    b_hrdata = 32'h1234_5678;
    tick();
    hreset   = 1'b1;
    b_hready = 1'b0;
    b_hresp  = 1'b1;
    settle();
    chk("t6_b_htrans_rst", 32'(b_htrans), 32'h0);
    chk("t6_m0_hready_rst", 32'(m_hready[0]), 32'h1);
    chk("t6_m1_hready_rst", 32'(m_hready[1]), 32'h1);
    chk("t6_m0_hresp_rst", 32'(m_hresp[0]), 32'h0);
    chk("t6_m1_hresp_rst", 32'(m_hresp[1]), 32'h0);
    tick();
    hreset = 1'b0;
    idle_all();
    b_hrdata = 32'hFFFF_0000;
    settle();
    chk("t6_h_hrdata_post", m_hrdata[h], 32'h0);
    chk("t6_w_hrdata_post", m_hrdata[w], 32'h0);
    chk("t6_hmaster_post", 32'(hmaster), 32'h0);
    chk("t6_b_htrans_post", 32'(b_htrans), 32'h0);
    chk("t6_m0_hready_post", 32'(m_hready[0]), 32'h1);
    chk("t6_m1_hready_post", 32'(m_hready[1]), 32'h1);
    tick();

    // Randomized traffic against per-master reference memories
    do_reset();
    for (int k = 0; k < 512; k++) begin
      ref_mem[k] = (32'(k) * 32'h0101_0101) ^ 32'h5A5A_0000;
      slv_mem[k] = ref_mem[k];
    end
    ap_v = 2'b00; dp_v = 2'b00; ap_wr = 2'b00; dp_wr = 2'b00;
    ap_addr = '0; ap_wdata = '0; dp_addr = '0; dp_wdata = '0;
    wait_cnt[0] = 0; wait_cnt[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;
    s_v = 1'b0; s_wr = 1'b0; s_errph = 1'b0; s_addr = 32'h0; s_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        m_htrans[i] = ap_v[i] ? NONSEQ : IDLE;
        m_haddr[i]  = ap_addr[i];
        m_hwrite[i] = ap_wr[i];
        m_hwdata[i] = (dp_v[i] && dp_wr[i]) ? dp_wdata[i] : $urandom();
      end
      if (!s_v) begin
        b_hready = 1'b1; b_hresp = 1'b0; b_hrdata = $urandom();
      end else if (s_wait != 0) begin
        b_hready = 1'b0; b_hresp = 1'b0; b_hrdata = $urandom();
      end else if (is_err(s_addr)) begin
        b_hready = s_errph; b_hresp = 1'b1; b_hrdata = $urandom();
      end else begin
        b_hready = 1'b1; b_hresp = 1'b0;
        b_hrdata = s_wr ? $urandom() : slv_mem[s_addr[10:2]];
      end
      settle();
      for (int i = 0; i < 2; i++) begin
        if (m_hready[i]) begin
          if (dp_v[i]) begin
            chk("rnd_hresp", 32'(m_hresp[i]), 32'(is_err(dp_addr[i])));
            if (!dp_wr[i] && !is_err(dp_addr[i]))
              chk("rnd_hrdata", m_hrdata[i], ref_mem[dp_addr[i][10:2]]);
            if (dp_wr[i] && !is_err(dp_addr[i]))
              ref_mem[dp_addr[i][10:2]] = dp_wdata[i];
            done_cnt[i]++;
          end
          dp_v[i] = ap_v[i]; dp_addr[i] = ap_addr[i];
          dp_wr[i] = ap_wr[i]; dp_wdata[i] = ap_wdata[i];
          if (cyc < 2900 && $urandom_range(0, 9) < 7) begin
            ap_v[i]     = 1'b1;
            ap_addr[i]  = base_of(i) + 32'(4 * $urandom_range(0, 15));
            ap_wr[i]    = 1'($urandom_range(0, 1));
            ap_wdata[i] = $urandom();
          end else begin
            ap_v[i] = 1'b0;
          end
          wait_cnt[i] = 0;
        end else if (ap_v[i]) begin
          wait_cnt[i]++;
          chk("rnd_wait_bound", 32'(wait_cnt[i] <= WAIT_LIMIT), 32'h1);
        end
      end
      if (b_hready) begin
        if (s_v && s_wr && !is_err(s_addr)) slv_mem[s_addr[10:2]] = b_hwdata;
        if (b_htrans[1]) begin
          s_v = 1'b1; s_addr = b_haddr; s_wr = b_hwrite; s_errph = 1'b0;
          s_wait = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        end else begin
          s_v = 1'b0;
        end
      end else begin
        if (s_wait != 0) s_wait--;
        else             s_errph = 1'b1;
      end
      tick();
    end
    chk("rnd_m0_progress", 32'(done_cnt[0] > 100), 32'h1);
    chk("rnd_m1_progress", 32'(done_cnt[1] > 100), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
